traffic_light_monitor: RTL and testbench
========================================

// Module: traffic_light_monitor
// PURPOSE
//  Passive checker on the output side of traffic_controller_fsm. It samples the four approach light codes and
//  night_mode every clock, and checks each phase for safety, sequence and timing.
//  It reports the first violation found, as a sticky fault with a cause code, and counts completed green phases.
//  It sits beside the controller in the top level and feeds the maintenance/status logic.
// PARAMETERS
//  T_GREEN   100  nominal green length, cycles (maximum allowed; an ambulance pre-empt may end green earlier)
//  T_YELLOW  20   required yellow length, cycles (exact)
//  T_FLASH   5    night-mode flash half-period, cycles (exact, YEL/OFF alternate)
//  T_TOL     2    extra cycles tolerated on top of T_GREEN
// PORTS
//  clk          in   1   system clock, rising edge
//  reset        in   1   asynchronous, active-low reset (0 = reset)
//  R1_light..R4_light in 24 ASCII light code per approach: "RED"=24'h524544 "GRN"=24'h47524E "YEL"=24'h59454C "OFF"=24'h4F4646
//  night_mode   in   1   night-mode request as driven to the controller
//  fault_clr    in   1   one-cycle pulse; clears the sticky fault and re-arms the monitor
//  fault        out  1   sticky: a violation has been detected
//  fault_code   out  3   cause of first fault: 0 none, 1 bad code, 2 conflict, 3 sequence, 4 green long, 5 yellow len, 6 flash
//  fault_road   out  2   approach index (0=R1..3=R4) of the first fault; 0 for conflict
//  phase_cnt    out  16  completed GRN->YEL->RED phases; wraps at 16'hFFFF -> 0
//  mon_state    out  2   0 SYNC, 1 NORMAL, 2 NIGHT, 3 FAULT
// BEHAVIOUR
//  Reset (reset=0, async): fault=0, fault_code=0, fault_road=0, phase_cnt=0, mon_state=SYNC. Internal counters and
//   previous-code registers are cleared. Reset released mid-phase: monitoring restarts from SYNC.
//  Decode per approach each cycle into RED/GRN/YEL/OFF/BAD. The previous-cycle code of each approach is registered.
//  All fault checks below are made on the registered sample. fault/fault_code/fault_road update 1 cycle after the offending sample.
//  SYNC: no checks. Go to NORMAL when all four approaches = RED, or exactly one approach is non-RED and that one is GRN.
//   Go to NIGHT when night_mode=1 and all four approaches are YEL or OFF. Otherwise stay in SYNC.
//  NORMAL:
//   - any BAD code -> fault 1 (lowest-index offender); >1 non-RED approach -> fault 2
//   - run counter counts cycles the active approach holds the same code; it reloads to 1 on every code change
//   - legal transitions: RED->GRN, GRN->YEL, YEL->RED; GRN->RED or RED->YEL or YEL->GRN -> fault 3
//   - GRN run > T_GREEN+T_TOL -> fault 4, flagged the cycle the count exceeds the limit (a phase need not end)
//   - YEL run != T_YELLOW at the YEL->RED change, or YEL run > T_YELLOW while still yellow -> fault 5
//   - YEL->RED after legal GRN/YEL durations: phase_cnt +1 in the same cycle as the check
//   - night_mode=1 and all approaches in {YEL,OFF} -> NIGHT; a phase in progress is abandoned without a fault
//  NIGHT:
//   - all four approaches must show the same code, either YEL or OFF. Otherwise fault 2, or fault 1 if any code is BAD.
//   - the first toggle after entering NIGHT only arms the check and is not measured
//   - every later toggle must occur after exactly T_FLASH cycles, else fault 6
//   - night_mode=0 and all approaches RED -> SYNC; any other non-night pattern while night_mode=0 -> SYNC (no fault)
//  FAULT:
//   - entered on any fault
//   - only the first cause is kept; later or simultaneous causes are ignored
//   - priority within one cycle: 1 > 2 > 3 > 4 > 5 > 6
//   - phase_cnt freezes
//   - fault_clr=1 -> fault=0, code=0, road=0, state SYNC next cycle
//   - fault_clr in the same cycle as a new fault: the clear wins and the new fault is dropped
//   - phase_cnt is never cleared by fault_clr
// TESTING
//  1 Reset, then a legal cycle R1..R4 (GRN 100, YEL 20) x2 -> fault=0, phase_cnt=8, mon_state=1 throughout NORMAL.
//  2 R1 GRN and R3 GRN in the same cycle -> next cycle fault=1, fault_code=2, fault_road=0, mon_state=3.
//  3 R2 YEL held 19 cycles, then RED -> fault_code=5, fault_road=1; then pulse fault_clr -> fault=0, mon_state=0.
//  4 R4 GRN held 103 cycles -> fault_code=4, fault_road=3, flagged on cycle 103.
//  5 night_mode=1, all approaches YEL/OFF toggling every 5 cycles for 60 cycles -> no fault.
//    Then one 4-cycle half-period -> fault_code=6.
//  6 R3 light=24'h414141 with reset asserted mid-run -> outputs zero immediately; after release, state SYNC.
//    Then an all-RED frame -> NORMAL.

Source files
------------

// File: rtl/traffic_light_monitor.sv
// Passive checker beside the traffic controller: validates light safety, sequence and
// timing per approach, latches the first violation and counts completed phases.
module traffic_light_monitor #(
   parameter int T_GREEN  = 100,
   parameter int T_YELLOW = 20,
   parameter int T_FLASH  = 5,
   parameter int T_TOL    = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [23:0] R1_light,
   input  logic [23:0] R2_light,
   input  logic [23:0] R3_light,
   input  logic [23:0] R4_light,
   input  logic        night_mode,
   input  logic        fault_clr,
   output logic        fault,
   output logic [2:0]  fault_code,
   output logic [1:0]  fault_road,
   output logic [15:0] phase_cnt,
   output logic [1:0]  mon_state
);

   // state  | meaning
   // SYNC   | waiting for a recognisable light pattern; nothing is checked
   // NORMAL | day sequencing: safety, sequence and phase timing checked
   // NIGHT  | all-approach flash: common pattern and half-period checked
   // FAULT  | first violation held until fault_clr
   typedef enum logic [1:0] {
      S_SYNC   = 2'd0,
      S_NORMAL = 2'd1,
      S_NIGHT  = 2'd2,
      S_FAULT  = 2'd3
   } state_e;

   typedef enum logic [2:0] {
      C_RED = 3'd0,
      C_GRN = 3'd1,
      C_YEL = 3'd2,
      C_OFF = 3'd3,
      C_BAD = 3'd4
   } code_e;

   localparam int RUN_W = $clog2(T_GREEN + T_TOL + T_YELLOW + T_FLASH + 2) + 1;
   localparam logic [RUN_W-1:0] GRN_LIM = RUN_W'(T_GREEN + T_TOL);
   localparam logic [RUN_W-1:0] YEL_LEN = RUN_W'(T_YELLOW);
   localparam logic [RUN_W-1:0] FLS_LEN = RUN_W'(T_FLASH);

   function automatic code_e decode(input logic [23:0] l);
      case (l)
         24'h524544: return C_RED;
         24'h47524E: return C_GRN;
         24'h59454C: return C_YEL;
         24'h4F4646: return C_OFF;
         default:    return C_BAD;
      endcase
   endfunction

   function automatic logic legal(input code_e p, input code_e c);
      return (p == C_RED && c == C_GRN) || (p == C_GRN && c == C_YEL) ||
             (p == C_YEL && c == C_RED);
   endfunction

   state_e           state_q;
   code_e            prev_q [4];
   code_e            cur    [4];
   logic [RUN_W-1:0] run_q, run_d;
   logic             armed_q;
   logic             fault_q;
   logic [2:0]       code_q;
   logic [1:0]       road_q;
   logic [15:0]      phase_q;

   logic [2:0] n_nonred;
   logic [1:0] act, bad_road, seq_road, yel_road;
   logic       bad, all_red, night_pat, flash_ok, seq_bad, yel_end, toggle;
   logic       grn_long, yel_long, yel_short, phase_done, flash_bad;
   logic [2:0] nrm_code, ngt_code;
   logic [1:0] nrm_road, ngt_road;

   always_comb begin
      cur[0] = decode(R1_light);
      cur[1] = decode(R2_light);
      cur[2] = decode(R3_light);
      cur[3] = decode(R4_light);
   end

   // Scanning from R4 down to R1 leaves the lowest-index offender in each *_road.
   always_comb begin
      n_nonred  = '0;
      act       = '0;
      bad       = 1'b0;
      bad_road  = '0;
      night_pat = 1'b1;
      flash_ok  = 1'b1;
      seq_bad   = 1'b0;
      seq_road  = '0;
      yel_end   = 1'b0;
      yel_road  = '0;
      for (int i = 3; i >= 0; i--) begin
         if (cur[i] != C_RED) begin
            n_nonred = n_nonred + 3'd1;
            act      = 2'(i);
         end
         if (cur[i] == C_BAD) begin
            bad      = 1'b1;
            bad_road = 2'(i);
         end
         if (cur[i] != C_YEL && cur[i] != C_OFF) night_pat = 1'b0;
         if (cur[i] != cur[0]) flash_ok = 1'b0;
         if (cur[i] != prev_q[i] && !legal(prev_q[i], cur[i])) begin
            seq_bad  = 1'b1;
            seq_road = 2'(i);
         end
         if (prev_q[i] == C_YEL && cur[i] == C_RED) begin
            yel_end  = 1'b1;
            yel_road = 2'(i);
         end
      end
      all_red  = (n_nonred == 3'd0);
      flash_ok = flash_ok & night_pat;
      toggle   = (cur[0] != prev_q[0]);

      if (all_red)                      run_d = '0;
      else if (cur[act] != prev_q[act]) run_d = RUN_W'(1);
      else if (&run_q)                  run_d = run_q;
      else                              run_d = run_q + 1'b1;

      grn_long   = (cur[act] == C_GRN) && (run_d > GRN_LIM);
      yel_long   = (cur[act] == C_YEL) && (run_d > YEL_LEN);
      yel_short  = yel_end && (run_q != YEL_LEN);
      phase_done = yel_end && (run_q == YEL_LEN);
      flash_bad  = armed_q && (toggle ? (run_q != FLS_LEN) : (run_d > FLS_LEN));

      nrm_code = 3'd0;
      nrm_road = '0;
      if (bad) begin
         nrm_code = 3'd1;
         nrm_road = bad_road;
      end else if (n_nonred > 3'd1) begin
         nrm_code = 3'd2;
      end else if (seq_bad) begin
         nrm_code = 3'd3;
         nrm_road = seq_road;
      end else if (grn_long) begin
         nrm_code = 3'd4;
         nrm_road = act;
      end else if (yel_long) begin
         nrm_code = 3'd5;
         nrm_road = act;
      end else if (yel_short) begin
         nrm_code = 3'd5;
         nrm_road = yel_road;
      end

      ngt_code = 3'd0;
      ngt_road = '0;
      if (bad) begin
         ngt_code = 3'd1;
         ngt_road = bad_road;
      end else if (!flash_ok) begin
         ngt_code = 3'd2;
      end else if (flash_bad) begin
         ngt_code = 3'd6;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_SYNC;
         prev_q  <= '{default: C_RED};
         run_q   <= '0;
         armed_q <= 1'b0;
         fault_q <= 1'b0;
         code_q  <= '0;
         road_q  <= '0;
         phase_q <= '0;
      end else begin
         prev_q <= cur;
         run_q  <= run_d;
         case (state_q)
            S_SYNC: begin
               armed_q <= 1'b0;
               if (night_mode && night_pat) state_q <= S_NIGHT;
               else if (all_red || (n_nonred == 3'd1 && cur[act] == C_GRN)) state_q <= S_NORMAL;
            end
            S_NORMAL: begin
               armed_q <= 1'b0;
               // Night entry abandons any phase in progress without judging it.
               if (night_mode && night_pat) begin
                  state_q <= S_NIGHT;
               end else if (nrm_code != 3'd0) begin
                  if (fault_clr) begin
                     state_q <= S_SYNC;
                  end else begin
                     state_q <= S_FAULT;
                     fault_q <= 1'b1;
                     code_q  <= nrm_code;
                     road_q  <= nrm_road;
                  end
               end else if (phase_done) begin
                  phase_q <= phase_q + 16'd1;
               end
            end
            S_NIGHT: begin
               if (!night_mode && !flash_ok) begin
                  state_q <= S_SYNC;
               end else if (ngt_code != 3'd0) begin
                  if (fault_clr) begin
                     state_q <= S_SYNC;
                  end else begin
                     state_q <= S_FAULT;
                     fault_q <= 1'b1;
                     code_q  <= ngt_code;
                     road_q  <= ngt_road;
                  end
               end else if (toggle) begin
                  armed_q <= 1'b1;
               end
            end
            S_FAULT: begin
               if (fault_clr) begin
                  state_q <= S_SYNC;
                  fault_q <= 1'b0;
                  code_q  <= '0;
                  road_q  <= '0;
               end
            end
            default: state_q <= S_SYNC;
         endcase
      end
   end

   assign fault      = fault_q;
   assign fault_code = code_q;
   assign fault_road = road_q;
   assign phase_cnt  = phase_q;
   assign mon_state  = state_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Bench for traffic_light_monitor: directed light sequences, a timestamp-based reference
// model compared every cycle, and literal expectations at the key points.
`timescale 1ns/1ps
module tb_traffic_light_monitor;
   localparam logic [23:0] L_RED = 24'h524544;
   localparam logic [23:0] L_GRN = 24'h47524E;
   localparam logic [23:0] L_YEL = 24'h59454C;
   localparam logic [23:0] L_OFF = 24'h4F4646;
   localparam logic [23:0] L_BAD = 24'h414141;
   localparam int TG = 100, TY = 20, TF = 5, TT = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [23:0] r1 = L_RED, r2 = L_RED, r3 = L_RED, r4 = L_RED;
   logic        nm = 1'b0;
   logic        clr = 1'b0;
   logic        fault;
   logic [2:0]  fault_code;
   logic [1:0]  fault_road;
   logic [15:0] phase_cnt;
   logic [1:0]  mon_state;

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   traffic_light_monitor #(.T_GREEN(TG), .T_YELLOW(TY), .T_FLASH(TF), .T_TOL(TT)) dut (
      .clk(clk), .reset(rst_n),
      .R1_light(r1), .R2_light(r2), .R3_light(r3), .R4_light(r4),
      .night_mode(nm), .fault_clr(clr),
      .fault(fault), .fault_code(fault_code), .fault_road(fault_road),
      .phase_cnt(phase_cnt), .mon_state(mon_state)
   );

   always #5 clk = ~clk;

   // Reference model: 0 RED 1 GRN 2 YEL 3 OFF 4 BAD; states 0 SYNC 1 NORMAL 2 NIGHT 3 FAULT.
   // Durations come from the cycle stamp at which each approach last changed code.
   int m_state = 0, m_code = 0, m_road = 0, m_phase = 0;
   bit m_fault = 1'b0, m_armed = 1'b0;
   int m_prev [4] = '{0, 0, 0, 0};
   int m_since[4] = '{0, 0, 0, 0};
   int cyc = 0;

   function automatic int dec(input logic [23:0] l);
      if (l == L_RED) return 0;
      if (l == L_GRN) return 1;
      if (l == L_YEL) return 2;
      if (l == L_OFF) return 3;
      return 4;
   endfunction

   task automatic model_step();
      int  cur[4], held[4], was[4];
      bit  chg[4];
      int  nonred, ngrn, fc, fr;
      bit  all_red, all_yo, same, tog;
      cyc++;
      cur[0] = dec(r1); cur[1] = dec(r2); cur[2] = dec(r3); cur[3] = dec(r4);
      nonred = 0; ngrn = 0; all_red = 1; all_yo = 1; same = 1;
      for (int i = 0; i < 4; i++) begin
         chg[i]  = (cur[i] != m_prev[i]);
         was[i]  = cyc - m_since[i];
         held[i] = chg[i] ? 1 : cyc - m_since[i] + 1;
         if (cur[i] != 0) nonred++;
         if (cur[i] == 1) ngrn++;
         if (cur[i] != 0) all_red = 0;
         if (cur[i] != 2 && cur[i] != 3) all_yo = 0;
         if (cur[i] != cur[0]) same = 0;
      end
      same = same && all_yo;
      tog  = chg[0];
      fc = 0; fr = 0;
      case (m_state)
         0: begin
            if (nm && all_yo) begin m_state = 2; m_armed = 0; end
            else if (all_red || (nonred == 1 && ngrn == 1)) m_state = 1;
         end
         1: begin
            if (nm && all_yo) begin
               m_state = 2; m_armed = 0;
            end else begin
               for (int i = 0; i < 4; i++) if (fc == 0 && cur[i] == 4) begin fc = 1; fr = i; end
               if (fc == 0 && nonred > 1) begin fc = 2; fr = 0; end
               for (int i = 0; i < 4; i++)
                  if (fc == 0 && chg[i] && !((m_prev[i] == 0 && cur[i] == 1) ||
                      (m_prev[i] == 1 && cur[i] == 2) || (m_prev[i] == 2 && cur[i] == 0))) begin
                     fc = 3; fr = i;
                  end
               for (int i = 0; i < 4; i++) if (fc == 0 && cur[i] == 1 && held[i] > TG + TT) begin fc = 4; fr = i; end
               for (int i = 0; i < 4; i++) if (fc == 0 && cur[i] == 2 && held[i] > TY) begin fc = 5; fr = i; end
               for (int i = 0; i < 4; i++)
                  if (fc == 0 && m_prev[i] == 2 && cur[i] == 0 && was[i] != TY) begin fc = 5; fr = i; end
               if (fc != 0) begin
                  if (clr) m_state = 0;
                  else begin m_state = 3; m_fault = 1; m_code = fc; m_road = fr; end
               end else begin
                  for (int i = 0; i < 4; i++)
                     if (m_prev[i] == 2 && cur[i] == 0) m_phase = (m_phase + 1) % 65536;
               end
            end
         end
         2: begin
            if (!nm && !same) begin
               m_state = 0;
            end else begin
               for (int i = 0; i < 4; i++) if (fc == 0 && cur[i] == 4) begin fc = 1; fr = i; end
               if (fc == 0 && !same) begin fc = 2; fr = 0; end
               if (fc == 0 && m_armed && ((tog && was[0] != TF) || (!tog && held[0] > TF))) begin fc = 6; fr = 0; end
               if (fc != 0) begin
                  if (clr) m_state = 0;
                  else begin m_state = 3; m_fault = 1; m_code = fc; m_road = fr; end
               end else if (tog) m_armed = 1;
            end
         end
         default: begin
            if (clr) begin m_state = 0; m_fault = 0; m_code = 0; m_road = 0; end
         end
      endcase
      for (int i = 0; i < 4; i++) begin
         if (chg[i]) m_since[i] = cyc;
         m_prev[i] = cur[i];
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_state = 0; m_code = 0; m_road = 0; m_phase = 0; m_fault = 0; m_armed = 0;
         for (int i = 0; i < 4; i++) begin m_prev[i] = 0; m_since[i] = 0; end
         cyc = 0;
      end else begin
         model_step();
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         checks++;
         if (fault !== m_fault || fault_code !== 3'(m_code) || fault_road !== 2'(m_road) ||
             phase_cnt !== 16'(m_phase) || mon_state !== 2'(m_state)) begin
            errors++;
            $display("FAIL model_cmp t=%0t dut f=%0b c=%0d r=%0d p=%0d s=%0d required f=%0b c=%0d r=%0d p=%0d s=%0d",
                     $time, fault, fault_code, fault_road, phase_cnt, mon_state,
                     m_fault, m_code, m_road, m_phase, m_state);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0d required %0d", name, act, exp);
      end
   endtask

   task automatic hold(input logic [23:0] a, b, c, d, input int n);
      r1 = a; r2 = b; r3 = c; r4 = d;
      repeat (n) @(negedge clk);
   endtask

   task automatic one(input int k, input logic [23:0] code, input int n);
      hold(k == 0 ? code : L_RED, k == 1 ? code : L_RED,
           k == 2 ? code : L_RED, k == 3 ? code : L_RED, n);
   endtask

   task automatic clear_fault();
      clr = 1'b1;
      hold(L_RED, L_RED, L_RED, L_RED, 1);
      clr = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(negedge clk);
      rst_n  = 1'b1;
      cmp_en = 1'b1;
      chk("reset_state", mon_state, 0);
      chk("reset_fault", fault, 0);
      chk("reset_phase", phase_cnt, 0);

      // 1: two legal laps R1..R4
      hold(L_RED, L_RED, L_RED, L_RED, 3);
      chk("t1_normal", mon_state, 1);
      for (int lap = 0; lap < 2; lap++)
         for (int k = 0; k < 4; k++) begin
            one(k, L_GRN, TG);
            one(k, L_YEL, TY);
         end
      hold(L_RED, L_RED, L_RED, L_RED, 2);
      chk("t1_phase_cnt", phase_cnt, 8);
      chk("t1_fault", fault, 0);
      chk("t1_state", mon_state, 1);

      // 2: conflicting greens
      hold(L_GRN, L_RED, L_GRN, L_RED, 1);
      chk("t2_fault", fault, 1);
      chk("t2_code", fault_code, 2);
      chk("t2_road", fault_road, 0);
      chk("t2_state", mon_state, 3);
      clear_fault();
      hold(L_RED, L_RED, L_RED, L_RED, 1);

      // 3: short yellow on R2, then clear
      one(1, L_GRN, 30);
      one(1, L_YEL, 19);
      hold(L_RED, L_RED, L_RED, L_RED, 1);
      chk("t3_code", fault_code, 5);
      chk("t3_road", fault_road, 1);
      clear_fault();
      chk("t3_clr_fault", fault, 0);
      chk("t3_clr_state", mon_state, 0);
      chk("t3_phase_kept", phase_cnt, 8);
      hold(L_RED, L_RED, L_RED, L_RED, 1);

      // illegal GRN->RED, then clear colliding with a new fault
      one(0, L_GRN, 10);
      hold(L_RED, L_RED, L_RED, L_RED, 1);
      chk("seq_code", fault_code, 3);
      chk("seq_road", fault_road, 0);
      clear_fault();
      hold(L_RED, L_RED, L_RED, L_RED, 1);
      one(1, L_GRN, 5);
      clr = 1'b1;
      hold(L_RED, L_RED, L_RED, L_RED, 1);
      clr = 1'b0;
      chk("clr_wins_fault", fault, 0);
      chk("clr_wins_state", mon_state, 0);
      hold(L_RED, L_RED, L_RED, L_RED, 1);

      // 4: long green on R4
      one(3, L_GRN, TG + TT);
      chk("t4_green_at_limit", fault, 0);
      one(3, L_GRN, 1);
      chk("t4_code", fault_code, 4);
      chk("t4_road", fault_road, 3);
      clear_fault();
      hold(L_RED, L_RED, L_RED, L_RED, 1);

      // 5: night flash, then one short half-period
      nm = 1'b1;
      for (int h = 0; h < 12; h++) begin
         if (h % 2 == 0) hold(L_YEL, L_YEL, L_YEL, L_YEL, TF);
         else            hold(L_OFF, L_OFF, L_OFF, L_OFF, TF);
      end
      chk("t5_no_fault", fault, 0);
      chk("t5_state", mon_state, 2);
      hold(L_YEL, L_YEL, L_YEL, L_YEL, TF - 1);
      hold(L_OFF, L_OFF, L_OFF, L_OFF, 1);
      chk("t5_code", fault_code, 6);
      chk("t5_road", fault_road, 0);
      nm = 1'b0;
      clear_fault();
      hold(L_RED, L_RED, L_RED, L_RED, 1);

      // 6: bad code, then asynchronous reset mid-cycle
      hold(L_RED, L_RED, L_BAD, L_RED, 1);
      chk("t6_code", fault_code, 1);
      chk("t6_road", fault_road, 2);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_rst_fault", fault, 0);
      chk("t6_rst_code", fault_code, 0);
      chk("t6_rst_phase", phase_cnt, 0);
      chk("t6_rst_state", mon_state, 0);
      @(negedge clk);
      rst_n = 1'b1;
      hold(L_RED, L_RED, L_BAD, L_RED, 2);
      chk("t6_sync", mon_state, 0);
      hold(L_RED, L_RED, L_RED, L_RED, 1);
      chk("t6_normal", mon_state, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
